// File: rtl/tpm_spi_frame_tracker.sv
// tpm_spi_frame_tracker
//   Follows TPM-over-SPI frames from sniffer byte events.
//   Decodes the 4-byte header, counts TPM wait states and indexes data bytes.
//   Flags frames whose address hits MATCH_ADDR under MATCH_ADDR_MASK.
//   Define TPM_WAIT_TIMEOUT_EN to abort frames whose wait phase reaches
//   MAX_WAIT_STATES bytes without the TPM signalling ready.
module tpm_spi_frame_tracker #(
  parameter int unsigned NUM_DATA_BITS   = 8,
  parameter int unsigned MAX_XFER_SIZE   = 64,
  parameter logic [23:0] MATCH_ADDR      = 24'hD40024,
  parameter logic [23:0] MATCH_ADDR_MASK = 24'hFF0FFF,
  parameter int unsigned MAX_WAIT_STATES = 16
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     ss_active,
  input  logic                     byte_valid,
  input  logic [NUM_DATA_BITS-1:0] mosi_byte,
  input  logic [NUM_DATA_BITS-1:0] miso_byte,
  output logic                     hdr_valid,
  output logic                     is_read,
  output logic [7:0]               xfer_size,
  output logic [23:0]              addr,
  output logic                     addr_match,
  output logic [7:0]               wait_count,
  output logic                     data_valid,
  output logic [NUM_DATA_BITS-1:0] data_byte,
  output logic [6:0]               data_index,
  output logic                     data_last,
  output logic                     frame_done,
  output logic                     frame_error
);

`ifdef TPM_WAIT_TIMEOUT_EN
  localparam bit WAIT_TIMEOUT_EN = 1'b1;
`else
  localparam bit WAIT_TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT,
    S_DATA,
    S_END,
    S_DISCARD
  } state_t;

  state_t state_q, state_d, cur_state, post_state;

  logic       ss_prev_q;
  logic [1:0] hdr_cnt_q, hdr_cnt_d, hdr_cnt_eff;
  logic [7:0] byte0_q, byte0_d;
  logic [15:0] addr_hi_q, addr_hi_d;
  logic [6:0] data_cnt_q, data_cnt_d, data_cnt_eff;

  logic                     hdr_valid_q, hdr_valid_d;
  logic                     is_read_q, is_read_d;
  logic [7:0]               xfer_size_q, xfer_size_d;
  logic [23:0]              addr_q, addr_d;
  logic                     addr_match_q, addr_match_d;
  logic [7:0]               wait_count_q, wait_count_d;
  logic                     data_valid_q, data_valid_d;
  logic [NUM_DATA_BITS-1:0] data_byte_q, data_byte_d;
  logic [6:0]               data_index_q, data_index_d;
  logic                     data_last_q, data_last_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_error_q, frame_error_d;

  logic        new_frame;
  logic [7:0]  wait_eff, wait_inc_val, size_plus;
  logic [23:0] hdr_addr;
  logic        byte_ev, oversize_ev, hdr_done_ev, wait_ev, wait_end_ev;
  logic        timeout_ev, data_ev, last_ev, extra_ev, frame_end;

  // Event decode. A chip-select rise in IDLE is folded into an effective HDR
  // state with cleared counters, so a byte arriving in that same cycle still
  // counts as header byte 0.
  always_comb begin
    new_frame    = (state_q == S_IDLE) && ss_active && !ss_prev_q;
    cur_state    = new_frame ? S_HDR : state_q;
    hdr_cnt_eff  = new_frame ? '0 : hdr_cnt_q;
    data_cnt_eff = new_frame ? '0 : data_cnt_q;
    wait_eff     = new_frame ? '0 : wait_count_q;
    wait_inc_val = (wait_eff == 8'hFF) ? 8'hFF : wait_eff + 8'd1;
    size_plus    = {1'b0, mosi_byte[6:0]} + 8'd1;
    hdr_addr     = {addr_hi_q, mosi_byte[7:0]};

    byte_ev     = byte_valid && (cur_state != S_IDLE);
    oversize_ev = byte_ev && (cur_state == S_HDR) && (hdr_cnt_eff == 2'd0) &&
                  (32'(size_plus) > MAX_XFER_SIZE);
    hdr_done_ev = byte_ev && (cur_state == S_HDR) && (hdr_cnt_eff == 2'd3);
    wait_ev     = byte_ev && (cur_state == S_WAIT);
    wait_end_ev = wait_ev && miso_byte[0];
    timeout_ev  = WAIT_TIMEOUT_EN && wait_ev && !miso_byte[0] &&
                  (32'(wait_inc_val) >= MAX_WAIT_STATES);
    data_ev     = byte_ev && (cur_state == S_DATA);
    last_ev     = data_ev && ({1'b0, data_cnt_eff} == (xfer_size_q - 8'd1));
    extra_ev    = byte_ev && (cur_state == S_END);
    frame_end   = (cur_state != S_IDLE) && !ss_active;
  end

  // State and frame bookkeeping registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ss_prev_q  <= 1'b0;
      hdr_cnt_q  <= '0;
      byte0_q    <= '0;
      addr_hi_q  <= '0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ss_prev_q  <= ss_active;
      hdr_cnt_q  <= hdr_cnt_d;
      byte0_q    <= byte0_d;
      addr_hi_q  <= addr_hi_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  // Next state: the byte is applied first (post_state), then a chip-select
  // fall in the same cycle closes the frame.
  always_comb begin
    post_state = cur_state;
    case (cur_state)
      S_HDR: begin
        if (oversize_ev)      post_state = S_DISCARD;
        else if (hdr_done_ev) post_state = miso_byte[0] ? S_DATA : S_WAIT;
      end
      S_WAIT: begin
        if (timeout_ev)       post_state = S_DISCARD;
        else if (wait_end_ev) post_state = S_DATA;
      end
      S_DATA: begin
        if (last_ev) post_state = S_END;
      end
      S_END: begin
        if (extra_ev) post_state = S_DISCARD;
      end
      default: ;
    endcase
    state_d = frame_end ? S_IDLE : post_state;

    hdr_cnt_d = hdr_cnt_eff;
    byte0_d   = byte0_q;
    addr_hi_d = addr_hi_q;
    if (byte_ev && (cur_state == S_HDR)) begin
      hdr_cnt_d = hdr_cnt_eff + 2'd1;
      case (hdr_cnt_eff)
        2'd0:    byte0_d          = mosi_byte[7:0];
        2'd1:    addr_hi_d[15:8]  = mosi_byte[7:0];
        2'd2:    addr_hi_d[7:0]   = mosi_byte[7:0];
        default: ;
      endcase
    end

    data_cnt_d = data_cnt_eff;
    if (data_ev) data_cnt_d = data_cnt_eff + 7'd1;
  end

  // Output next values: pulses default low, header/data fields hold.
  always_comb begin
    hdr_valid_d  = hdr_done_ev;
    is_read_d    = is_read_q;
    xfer_size_d  = xfer_size_q;
    addr_d       = addr_q;
    addr_match_d = addr_match_q;
    if (hdr_done_ev) begin
      is_read_d    = byte0_q[7];
      xfer_size_d  = {1'b0, byte0_q[6:0]} + 8'd1;
      addr_d       = hdr_addr;
      addr_match_d = ((hdr_addr ^ MATCH_ADDR) & MATCH_ADDR_MASK) == 24'd0;
    end

    wait_count_d = wait_eff;
    if (wait_ev) wait_count_d = wait_inc_val;

    data_valid_d = data_ev;
    data_byte_d  = data_byte_q;
    data_index_d = data_index_q;
    data_last_d  = last_ev;
    if (data_ev) begin
      data_byte_d  = is_read_q ? miso_byte : mosi_byte;
      data_index_d = data_cnt_eff;
    end

    frame_done_d  = frame_end && (post_state == S_END);
    frame_error_d = oversize_ev || timeout_ev || extra_ev ||
                    (frame_end && ((post_state == S_HDR) ||
                                   (post_state == S_WAIT) ||
                                   (post_state == S_DATA)));
  end

  // Registered outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hdr_valid_q   <= 1'b0;
      is_read_q     <= 1'b0;
      xfer_size_q   <= '0;
      addr_q        <= '0;
      addr_match_q  <= 1'b0;
      wait_count_q  <= '0;
      data_valid_q  <= 1'b0;
      data_byte_q   <= '0;
      data_index_q  <= '0;
      data_last_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      hdr_valid_q   <= hdr_valid_d;
      is_read_q     <= is_read_d;
      xfer_size_q   <= xfer_size_d;
      addr_q        <= addr_d;
      addr_match_q  <= addr_match_d;
      wait_count_q  <= wait_count_d;
      data_valid_q  <= data_valid_d;
      data_byte_q   <= data_byte_d;
      data_index_q  <= data_index_d;
      data_last_q   <= data_last_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign hdr_valid   = hdr_valid_q;
  assign is_read     = is_read_q;
  assign xfer_size   = xfer_size_q;
  assign addr        = addr_q;
  assign addr_match  = addr_match_q;
  assign wait_count  = wait_count_q;
  assign data_valid  = data_valid_q;
  assign data_byte   = data_byte_q;
  assign data_index  = data_index_q;
  assign data_last   = data_last_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_tpm_spi_frame_tracker.sv
// Directed bench for tpm_spi_frame_tracker (MAX_WAIT_STATES overridden to 4).
module tb_tpm_spi_frame_tracker;
  logic        sys_clk = 1'b0;
  logic        rst, ss_active, byte_valid;
  logic [7:0]  mosi_byte, miso_byte;
  logic        hdr_valid, is_read, addr_match, data_valid, data_last;
  logic        frame_done, frame_error;
  logic [7:0]  xfer_size, wait_count, data_byte;
  logic [23:0] addr;
  logic [6:0]  data_index;

  int tests_run = 0;
  int tests_failed = 0;

  int n_hdr = 0, n_done = 0, n_err = 0, n_both = 0, n_data = 0;
  logic [7:0] cap_data [0:1023];
  logic [6:0] cap_idx  [0:1023];
  logic       cap_last [0:1023];

  tpm_spi_frame_tracker #(
    .NUM_DATA_BITS  (8),
    .MAX_XFER_SIZE  (64),
    .MATCH_ADDR     (24'hD40024),
    .MATCH_ADDR_MASK(24'hFF0FFF),
    .MAX_WAIT_STATES(4)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .ss_active  (ss_active),
    .byte_valid (byte_valid),
    .mosi_byte  (mosi_byte),
    .miso_byte  (miso_byte),
    .hdr_valid  (hdr_valid),
    .is_read    (is_read),
    .xfer_size  (xfer_size),
    .addr       (addr),
    .addr_match (addr_match),
    .wait_count (wait_count),
    .data_valid (data_valid),
    .data_byte  (data_byte),
    .data_index (data_index),
    .data_last  (data_last),
    .frame_done (frame_done),
    .frame_error(frame_error)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse monitor: cumulative counts and captured data-phase bytes.
  always @(posedge sys_clk) begin
    #1;
    if (hdr_valid) n_hdr++;
    if (frame_done) n_done++;
    if (frame_error) n_err++;
    if (frame_done && frame_error) n_both++;
    if (data_valid && n_data < 1024) begin
      cap_data[n_data] = data_byte;
      cap_idx[n_data]  = data_index;
      cap_last[n_data] = data_last;
      n_data++;
    end
  end

  task automatic send_byte(input logic [7:0] mo, input logic [7:0] mi);
    @(negedge sys_clk);
    byte_valid = 1'b1; mosi_byte = mo; miso_byte = mi;
    @(negedge sys_clk);
    byte_valid = 1'b0;
  endtask

  task automatic ss_up();
    @(negedge sys_clk); ss_active = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic ss_down();
    @(negedge sys_clk); ss_active = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic send_hdr(input logic [7:0] b0, input logic [23:0] a, input logic ready);
    send_byte(b0, 8'h00);
    send_byte(a[23:16], 8'h00);
    send_byte(a[15:8], 8'h00);
    send_byte(a[7:0], {7'b0, ready});
  endtask

  task automatic test_reset();
    rst = 1'b1; ss_active = 1'b0; byte_valid = 1'b0; mosi_byte = '0; miso_byte = '0;
    repeat (3) @(negedge sys_clk);
    tests_run++; if ({hdr_valid, is_read, xfer_size, addr, addr_match} !== 35'd0) begin tests_failed++; $display("FAIL reset_hdr_fields: got %0h expected 0", {hdr_valid, is_read, xfer_size, addr, addr_match}); end
    tests_run++; if ({wait_count, data_valid, data_byte, data_index, data_last} !== 25'd0) begin tests_failed++; $display("FAIL reset_data_fields: got %0h expected 0", {wait_count, data_valid, data_byte, data_index, data_last}); end
    tests_run++; if ({frame_done, frame_error} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 00", {frame_done, frame_error}); end
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    tests_run++; if ({hdr_valid, data_valid, frame_done, frame_error, wait_count} !== 12'd0) begin tests_failed++; $display("FAIL reset_release: got %0h expected 0", {hdr_valid, data_valid, frame_done, frame_error, wait_count}); end
  endtask

  task automatic test_read_1b();
    int h0, dn0, e0, d0;
    h0 = n_hdr; dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'h80, 24'hD40024, 1'b1);
    send_byte(8'h00, 8'h80);
    ss_down();
    tests_run++; if (n_hdr - h0 !== 1) begin tests_failed++; $display("FAIL rd1_hdr_count: got %0d expected 1", n_hdr - h0); end
    tests_run++; if (is_read !== 1'b1) begin tests_failed++; $display("FAIL rd1_is_read: got %b expected 1", is_read); end
    tests_run++; if (xfer_size !== 8'd1) begin tests_failed++; $display("FAIL rd1_size: got %0d expected 1", xfer_size); end
    tests_run++; if (addr !== 24'hD40024) begin tests_failed++; $display("FAIL rd1_addr: got %h expected d40024", addr); end
    tests_run++; if (addr_match !== 1'b1) begin tests_failed++; $display("FAIL rd1_match: got %b expected 1", addr_match); end
    tests_run++; if (wait_count !== 8'd0) begin tests_failed++; $display("FAIL rd1_waits: got %0d expected 0", wait_count); end
    tests_run++; if (n_data - d0 !== 1) begin tests_failed++; $display("FAIL rd1_data_count: got %0d expected 1", n_data - d0); end
    tests_run++; if ({cap_data[d0], cap_idx[d0], cap_last[d0]} !== {8'h80, 7'd0, 1'b1}) begin tests_failed++; $display("FAIL rd1_data: got %h/%0d/%b expected 80/0/1", cap_data[d0], cap_idx[d0], cap_last[d0]); end
    tests_run++; if ({n_done - dn0, n_err - e0} !== {32'd1, 32'd0}) begin tests_failed++; $display("FAIL rd1_done_err: got done=%0d err=%0d expected 1/0", n_done - dn0, n_err - e0); end
  endtask

  task automatic test_write_waits();
    int dn0, e0, d0;
    logic [7:0] exp_d [0:3];
    exp_d[0] = 8'h80; exp_d[1] = 8'h01; exp_d[2] = 8'h00; exp_d[3] = 8'h00;
    dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'h03, 24'hD40024, 1'b0);
    send_byte(8'hEE, 8'h00);
    send_byte(8'hEE, 8'h01);
    for (int i = 0; i < 4; i++) send_byte(exp_d[i], 8'hFF);
    ss_down();
    tests_run++; if ({is_read, xfer_size} !== {1'b0, 8'd4}) begin tests_failed++; $display("FAIL wr4_hdr: got rd=%b size=%0d expected 0/4", is_read, xfer_size); end
    tests_run++; if (wait_count !== 8'd2) begin tests_failed++; $display("FAIL wr4_waits: got %0d expected 2", wait_count); end
    tests_run++; if (n_data - d0 !== 4) begin tests_failed++; $display("FAIL wr4_data_count: got %0d expected 4", n_data - d0); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if ({cap_data[d0+i], cap_idx[d0+i], cap_last[d0+i]} !== {exp_d[i], 7'(i), (i == 3)}) begin tests_failed++; $display("FAIL wr4_data%0d: got %h/%0d/%b expected %h/%0d/%b", i, cap_data[d0+i], cap_idx[d0+i], cap_last[d0+i], exp_d[i], i, (i == 3)); end
    end
    tests_run++; if ({n_done - dn0, n_err - e0} !== {32'd1, 32'd0}) begin tests_failed++; $display("FAIL wr4_done_err: got done=%0d err=%0d expected 1/0", n_done - dn0, n_err - e0); end
  endtask

  task automatic test_locality();
    logic [23:0] addrs [0:1];
    logic        exp_m [0:1];
    int dn0, e0, d0;
    addrs[0] = 24'hD41024; exp_m[0] = 1'b1;
    addrs[1] = 24'hD40018; exp_m[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dn0 = n_done; e0 = n_err; d0 = n_data;
      ss_up();
      send_hdr(8'h84, addrs[k], 1'b1);
      for (int i = 0; i < 5; i++) send_byte(8'h00, 8'h10 + 8'(i));
      ss_down();
      tests_run++; if ({addr, addr_match, xfer_size} !== {addrs[k], exp_m[k], 8'd5}) begin tests_failed++; $display("FAIL loc%0d_hdr: got %h/%b/%0d expected %h/%b/5", k, addr, addr_match, xfer_size, addrs[k], exp_m[k]); end
      tests_run++; if ({cap_data[d0+4], cap_last[d0+4], cap_last[d0+3]} !== {8'h14, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL loc%0d_last: got %h/%b/%b expected 14/1/0", k, cap_data[d0+4], cap_last[d0+4], cap_last[d0+3]); end
      tests_run++; if ({n_done - dn0, n_err - e0, n_data - d0} !== {32'd1, 32'd0, 32'd5}) begin tests_failed++; $display("FAIL loc%0d_done: got done=%0d err=%0d data=%0d expected 1/0/5", k, n_done - dn0, n_err - e0, n_data - d0); end
    end
  endtask

  task automatic test_short_frame();
    int h0, dn0, e0, d0;
    dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'h03, 24'hD40024, 1'b1);
    send_byte(8'hA1, 8'h00);
    send_byte(8'hA2, 8'h00);
    ss_down();
    tests_run++; if ({n_done - dn0, n_err - e0, n_data - d0} !== {32'd0, 32'd1, 32'd2}) begin tests_failed++; $display("FAIL short_err: got done=%0d err=%0d data=%0d expected 0/1/2", n_done - dn0, n_err - e0, n_data - d0); end
    h0 = n_hdr; dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'h80, 24'hD40024, 1'b1);
    send_byte(8'h00, 8'h42);
    ss_down();
    tests_run++; if ({n_hdr - h0, n_done - dn0, n_err - e0} !== {32'd1, 32'd1, 32'd0}) begin tests_failed++; $display("FAIL short_recover: got hdr=%0d done=%0d err=%0d expected 1/1/0", n_hdr - h0, n_done - dn0, n_err - e0); end
    tests_run++; if ({cap_data[d0], cap_last[d0], xfer_size} !== {8'h42, 1'b1, 8'd1}) begin tests_failed++; $display("FAIL short_recover_data: got %h/%b/%0d expected 42/1/1", cap_data[d0], cap_last[d0], xfer_size); end
  endtask

  task automatic test_extra_byte();
    int dn0, e0, d0;
    dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'h00, 24'hD40024, 1'b1);
    send_byte(8'h5A, 8'h00);
    tests_run++; if (n_err - e0 !== 0) begin tests_failed++; $display("FAIL extra_pre: got err=%0d expected 0", n_err - e0); end
    send_byte(8'h77, 8'h00);
    tests_run++; if (n_err - e0 !== 1) begin tests_failed++; $display("FAIL extra_err: got err=%0d expected 1", n_err - e0); end
    ss_down();
    tests_run++; if ({n_done - dn0, n_err - e0, n_data - d0} !== {32'd0, 32'd1, 32'd1}) begin tests_failed++; $display("FAIL extra_end: got done=%0d err=%0d data=%0d expected 0/1/1", n_done - dn0, n_err - e0, n_data - d0); end
    tests_run++; if (cap_data[d0] !== 8'h5A) begin tests_failed++; $display("FAIL extra_data: got %h expected 5a", cap_data[d0]); end
  endtask

  task automatic test_size_limits();
    int h0, dn0, e0, d0;
    h0 = n_hdr; dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'hC0, 24'hD40024, 1'b1);
    send_byte(8'h00, 8'h11);
    ss_down();
    tests_run++; if ({n_hdr - h0, n_done - dn0, n_err - e0, n_data - d0} !== {32'd0, 32'd0, 32'd1, 32'd0}) begin tests_failed++; $display("FAIL oversize: got hdr=%0d done=%0d err=%0d data=%0d expected 0/0/1/0", n_hdr - h0, n_done - dn0, n_err - e0, n_data - d0); end
    h0 = n_hdr; dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'hBF, 24'hD40024, 1'b1);
    for (int i = 0; i < 64; i++) send_byte(8'h00, 8'(i));
    ss_down();
    tests_run++; if ({n_hdr - h0, xfer_size} !== {32'd1, 8'd64}) begin tests_failed++; $display("FAIL max_size_hdr: got hdr=%0d size=%0d expected 1/64", n_hdr - h0, xfer_size); end
    tests_run++; if (n_data - d0 !== 64) begin tests_failed++; $display("FAIL max_size_count: got %0d expected 64", n_data - d0); end
    tests_run++; if ({cap_data[d0+63], cap_idx[d0+63], cap_last[d0+63], cap_last[d0+62]} !== {8'd63, 7'd63, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL max_size_last: got %0d/%0d/%b/%b expected 63/63/1/0", cap_data[d0+63], cap_idx[d0+63], cap_last[d0+63], cap_last[d0+62]); end
    tests_run++; if ({n_done - dn0, n_err - e0} !== {32'd1, 32'd0}) begin tests_failed++; $display("FAIL max_size_done: got done=%0d err=%0d expected 1/0", n_done - dn0, n_err - e0); end
  endtask

  task automatic test_wait_timeout();
    int dn0, e0, d0;
    dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'h00, 24'hD40024, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'hEE, 8'h00);
`ifdef TPM_WAIT_TIMEOUT_EN
    tests_run++; if ({n_err - e0, wait_count} !== {32'd1, 8'd4}) begin tests_failed++; $display("FAIL timeout_at4: got err=%0d waits=%0d expected 1/4", n_err - e0, wait_count); end
`else
    tests_run++; if ({n_err - e0, wait_count} !== {32'd0, 8'd4}) begin tests_failed++; $display("FAIL nolimit_at4: got err=%0d waits=%0d expected 0/4", n_err - e0, wait_count); end
`endif
    send_byte(8'hEE, 8'h00);
    send_byte(8'hEE, 8'h00);
`ifdef TPM_WAIT_TIMEOUT_EN
    tests_run++; if (wait_count !== 8'd4) begin tests_failed++; $display("FAIL timeout_waits: got %0d expected 4", wait_count); end
`else
    tests_run++; if (wait_count !== 8'd6) begin tests_failed++; $display("FAIL nolimit_waits: got %0d expected 6", wait_count); end
`endif
    ss_down();
    tests_run++; if ({n_done - dn0, n_err - e0, n_data - d0} !== {32'd0, 32'd1, 32'd0}) begin tests_failed++; $display("FAIL wait_end: got done=%0d err=%0d data=%0d expected 0/1/0", n_done - dn0, n_err - e0, n_data - d0); end
  endtask

  task automatic test_back_to_back();
    int dn0, e0, d0;
    dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'h00, 24'hD40024, 1'b1);
    @(negedge sys_clk);
    byte_valid = 1'b1; mosi_byte = 8'h3C; miso_byte = 8'h00; ss_active = 1'b0;
    @(negedge sys_clk);
    byte_valid = 1'b0;
    @(negedge sys_clk);
    tests_run++; if ({cap_data[d0], cap_last[d0], n_data - d0} !== {8'h3C, 1'b1, 32'd1}) begin tests_failed++; $display("FAIL b2b_data: got %h/%b/%0d expected 3c/1/1", cap_data[d0], cap_last[d0], n_data - d0); end
    tests_run++; if ({n_done - dn0, n_err - e0} !== {32'd1, 32'd0}) begin tests_failed++; $display("FAIL b2b_done: got done=%0d err=%0d expected 1/0", n_done - dn0, n_err - e0); end
    dn0 = n_done; e0 = n_err; d0 = n_data;
    ss_up();
    send_hdr(8'h80, 24'hD40018, 1'b1);
    send_byte(8'h00, 8'h99);
    ss_down();
    tests_run++; if ({n_done - dn0, n_err - e0, cap_data[d0], addr_match} !== {32'd1, 32'd0, 8'h99, 1'b0}) begin tests_failed++; $display("FAIL b2b_next: got done=%0d err=%0d data=%h match=%b expected 1/0/99/0", n_done - dn0, n_err - e0, cap_data[d0], addr_match); end
  endtask

  initial begin
    test_reset();
    test_read_1b();
    test_write_waits();
    test_locality();
    test_short_frame();
    test_extra_byte();
    test_size_limits();
    test_wait_timeout();
    test_back_to_back();
    tests_run++; if (n_both !== 0) begin tests_failed++; $display("FAIL done_and_error_together: got %0d expected 0", n_both); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
